// File: rtl/dmem_if.sv
// Request/response bus between a load/store unit (master) and the data-memory
// controller (slave).
interface dmem_if #(
  parameter int ADDR_W = 32
) ();
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              ld_unsigned;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [31:0]       rdata;

  modport master (
    output req, we, size, ld_unsigned, addr, wdata,
    input  busy, done, err, rdata
  );

  modport slave (
    input  req, we, size, ld_unsigned, addr, wdata,
    output busy, done, err, rdata
  );
endinterface

// File: rtl/dmem_ctrl.sv
// Word-organised data memory with big-endian byte/half/word access and a fixed
// number of wait states. Define DMEM_ALIGN_CHECK_EN to fault misaligned accesses.
module dmem_ctrl #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic   clk,
  input  logic   reset,
  dmem_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [IDX_W+1:0]   addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               err_q, err_d;

  logic [31:0]        mem [DEPTH_WORDS];

  logic               accept;
  logic               enter_done;
  logic               op_we;
  logic [1:0]         op_size;
  logic               op_uns;
  logic [IDX_W+1:0]   op_addr;
  logic [31:0]        op_wdata;
  logic [IDX_W-1:0]   op_idx;
  logic               fault;
  logic [1:0]         eff_size;
  logic [1:0]         off;
  logic [31:0]        word_rd;
  logic [3:0]         be;
  logic [31:0]        wr_word;
  logic [31:0]        ld_val;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;
  logic               mem_we;
  logic               unused_addr_hi;

  assign unused_addr_hi = ^bus.addr[ADDR_W-1:IDX_W+2];

  assign accept = bus.req && (state_q == S_IDLE || state_q == S_DONE);

  // With zero wait states the access completes on its own accepting edge, so
  // the operation must come straight from the bus rather than the latches.
  assign enter_done = (state_q == S_WAIT && cnt_q == 4'd0) ||
                      (accept && WAIT_CYCLES == 0);

  assign op_we    = accept ? bus.we               : we_q;
  assign op_size  = accept ? bus.size             : size_q;
  assign op_uns   = accept ? bus.ld_unsigned      : uns_q;
  assign op_addr  = accept ? bus.addr[IDX_W+1:0]  : addr_q;
  assign op_wdata = accept ? bus.wdata            : wdata_q;
  assign op_idx   = op_addr[IDX_W+1:2];
  assign word_rd  = mem[op_idx];

  // Size/offset decode: either fault misalignment or silently align it.
  always_comb begin
    fault    = 1'b0;
    eff_size = op_size;
    off      = op_addr[1:0];
`ifdef DMEM_ALIGN_CHECK_EN
    fault = (op_size == SZ_RSVD) ||
            (op_size == SZ_HALF && op_addr[0]) ||
            (op_size == SZ_WORD && op_addr[1:0] != 2'b00);
`else
    case (op_size)
      SZ_BYTE: off = op_addr[1:0];
      SZ_HALF: off = {op_addr[1], 1'b0};
      default: begin
        eff_size = SZ_WORD;
        off      = 2'b00;
      end
    endcase
`endif
  end

  // Big-endian lanes: byte offset 0 lives in bits [31:24].
  always_comb begin
    be      = 4'b0000;
    wr_word = op_wdata;
    ld_byte = 8'(word_rd >> {~off, 3'b000});
    ld_half = off[1] ? word_rd[15:0] : word_rd[31:16];
    ld_val  = word_rd;
    case (eff_size)
      SZ_BYTE: begin
        be      = 4'b1000 >> off;
        wr_word = {4{op_wdata[7:0]}};
        ld_val  = op_uns ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      end
      SZ_HALF: begin
        be      = off[1] ? 4'b0011 : 4'b1100;
        wr_word = {2{op_wdata[15:0]}};
        ld_val  = op_uns ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      end
      SZ_WORD: begin
        be      = 4'b1111;
        wr_word = op_wdata;
        ld_val  = word_rd;
      end
      default: begin
        be      = 4'b0000;
        wr_word = op_wdata;
        ld_val  = 32'd0;
      end
    endcase
  end

  assign mem_we = enter_done && op_we && !fault;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;

    case (state_q)
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      we_d    = bus.we;
      size_d  = bus.size;
      uns_d   = bus.ld_unsigned;
      addr_d  = bus.addr[IDX_W+1:0];
      wdata_d = bus.wdata;
      if (WAIT_CYCLES > 0) begin
        state_d = S_WAIT;
        cnt_d   = WAIT_INIT;
      end else begin
        state_d = S_DONE;
      end
    end

    if (enter_done) begin
      err_d = fault;
      if (fault)       rdata_d = 32'd0;
      else if (!op_we) rdata_d = ld_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // NOTE: the array has no reset; reset only blocks the pending write so contents survive.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[op_idx][8*i +: 8] <= wr_word[8*i +: 8];
      end
    end
  end

  assign bus.busy  = (state_q == S_WAIT);
  assign bus.done  = (state_q == S_DONE);
  assign bus.err   = (state_q == S_DONE) && err_q;
  assign bus.rdata = rdata_q;

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width.
REQ-002 SHALL have parameter DEPTH_WORDS, default 64, number of 32-bit words; power of two, minimum 4.
REQ-003 SHALL have parameter WAIT_CYCLES, default 1, extra access wait states; legal range 0..15.
REQ-004 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req  input  1  access request; sampled only when accept is possible (REQ-013).
REQ-007 SHALL have port we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port size  input  2  00 = byte, 01 = half, 10 = word, 11 = reserved.
REQ-009 SHALL have port ld_unsigned  input  1  1 = zero-extend sub-word loads, 0 = sign-extend.
REQ-010 SHALL have port addr  input  ADDR_W  byte address.
REQ-011 SHALL have port wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-012 SHALL have outputs busy (1, access in wait states), done (1, one-cycle completion pulse), err (1, completion with fault), rdata (32, load result).

Function
REQ-013 SHALL implement FSM IDLE, WAIT, DONE; a request is accepted when req=1 in state IDLE or DONE, latching we, size, ld_unsigned, addr, wdata.
REQ-014 SHALL transition on accept to WAIT when WAIT_CYCLES>0, otherwise directly to DONE.
REQ-015 SHALL remain in WAIT for exactly WAIT_CYCLES cycles, counted by a 4-bit down-counter, then enter DONE.
REQ-016 SHALL, in DONE, go to WAIT/DONE on a new accept, else to IDLE; back-to-back throughput is one access per WAIT_CYCLES+1 cycles.
REQ-017 SHALL assert busy only in WAIT, done only in DONE, and ignore req while busy=1 (no queueing).
REQ-018 SHALL make latency exactly WAIT_CYCLES+1 cycles from the accepting edge to the cycle in which done=1.
REQ-019 SHALL index the array by word = (addr >> 2) mod DEPTH_WORDS; higher address bits wrap silently.
REQ-020 SHALL use big-endian lanes: byte offset 0 = bits [31:24], offset 3 = bits [7:0]; half offset 0 = [31:16].
REQ-021 SHALL commit stores on the edge entering DONE, writing only the addressed lanes; the other lanes are unchanged.
REQ-022 SHALL, for loads, present the extracted and extended value on rdata while done=1 and hold it until the next load completion; stores leave rdata unchanged.
REQ-023 SHALL let a load accepted in DONE of a store to the same word return the newly stored data.
REQ-024 SHALL leave array contents uninitialised; no read-before-write guarantee.

Reset
REQ-025 SHALL, while reset=1 at an edge, force state IDLE, counter 0, busy 0, done 0, err 0, rdata 0; reset dominates req.
REQ-026 SHALL abort an in-flight access on reset; a pending store SHALL NOT be written; array contents are preserved.

Configuration
REQ-027 SHALL honour macro DMEM_ALIGN_CHECK_EN.
REQ-028 SHALL, with DMEM_ALIGN_CHECK_EN defined, flag half with addr[0]=1, word with addr[1:0]!=0, and size=11 as faults: done and err=1 together, no array write, rdata=0.
REQ-029 SHALL, without DMEM_ALIGN_CHECK_EN, force addresses aligned (clear addr[0] for half, addr[1:0] for word), treat size=11 as word, and tie err to 0.

Verification
REQ-030 SHALL test WAIT_CYCLES=1: store word 0x12345678 at addr 0x8, then load word at 0x8 -> done 2 cycles after each accept, rdata=0x12345678.
REQ-031 SHALL test lanes: after REQ-030, store byte 0xAB at 0x9, load byte signed at 0x9 -> rdata=0xFFFFFFAB; load unsigned -> 0x000000AB; load word 0x8 -> 0x12AB5678.
REQ-032 SHALL test half: store half 0x8001 at 0xA, load half signed at 0xA -> 0xFFFF8001; unsigned -> 0x00008001.
REQ-033 SHALL test wrap and back-to-back: DEPTH_WORDS=64, store word 0xCAFEF00D at 0x100, load issued in its DONE cycle at 0x0 -> rdata=0xCAFEF00D, no idle cycle between accesses.
REQ-034 SHALL test alignment: store word 0xFFFFFFFF at 0x6 -> with macro, err=1 and word 0x4 unchanged; without macro, err=0 and word 0x4 = 0xFFFFFFFF.
REQ-035 SHALL test reset abort: WAIT_CYCLES=3, store 0x55 to 0x10, reset=1 at wait cycle 2 -> busy/done/rdata=0 next cycle, word 0x10 keeps its old value.
